// File: rtl/sha1_round_core_if.sv
// Handshake and data bundle between the SHA-1 message schedule/user side and the round core.
interface sha1_round_core_if #(
  parameter int N = 32
);
  logic           start;
  logic           first_blk;
  logic [N-1:0]   w_in;
  logic [7:0]     t_out;
  logic           busy;
  logic           digest_valid;
  logic [5*N-1:0] digest;

  modport master (
    output start, first_blk, w_in,
    input  t_out, busy, digest_valid, digest
  );

  modport slave (
    input  start, first_blk, w_in,
    output t_out, busy, digest_valid, digest
  );
endinterface

// File: rtl/sha1_round_core.sv
// SHA-1 compression: 80 single-cycle rounds over A..E, then feed-forward into H0..H4.
module sha1_round_core #(
  parameter int N = 32
) (
  input logic              clk,
  input logic              rst_n,
  sha1_round_core_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_e;

  // Element 0 is H0 / A, element 4 is H4 / E.
  localparam logic [4:0][N-1:0] IV = {32'hC3D2E1F0, 32'h10325476, 32'h98BADCFE,
                                      32'hEFCDAB89, 32'h67452301};

  state_e            state_q, state_d;
  logic [7:0]        t_q, t_d;
  logic              dv_q, dv_d;
  logic [4:0][N-1:0] h_q, h_d;
  logic [4:0][N-1:0] wk_q, wk_d;
  logic [N-1:0]      t_sum;

  function automatic logic [N-1:0] rotl(input logic [N-1:0] x, input int s);
    return (x << s) | (x >> (N - s));
  endfunction

  function automatic logic [N-1:0] f_round(input logic [7:0] k, input logic [N-1:0] b,
                                           input logic [N-1:0] c, input logic [N-1:0] d);
    if (k < 8'd20)      return (b & c) | (~b & d);
    else if (k < 8'd40) return b ^ c ^ d;
    else if (k < 8'd60) return (b & c) | (b & d) | (c & d);
    else                return b ^ c ^ d;
  endfunction

  function automatic logic [N-1:0] k_const(input logic [7:0] k);
    if (k < 8'd20)      return 32'h5A827999;
    else if (k < 8'd40) return 32'h6ED9EBA1;
    else if (k < 8'd60) return 32'h8F1BBCDC;
    else                return 32'hCA62C1D6;
  endfunction

  // w_in reaches only this adder, which lands in register A.
  assign t_sum = rotl(wk_q[0], 5) + f_round(t_q, wk_q[1], wk_q[2], wk_q[3])
               + wk_q[4] + k_const(t_q) + bus.w_in;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    dv_d    = 1'b0;
    h_d     = h_q;
    wk_d    = wk_q;
    unique case (state_q)
      IDLE: begin
        t_d = '0;
        if (bus.start) begin
          if (bus.first_blk) h_d = IV;
          wk_d    = h_d;
          state_d = ROUND;
        end
      end
      ROUND: begin
        wk_d = {wk_q[3], wk_q[2], rotl(wk_q[1], 30), wk_q[0], t_sum};
        if (t_q == 8'd79) state_d = FINAL;
        else              t_d     = t_q + 8'd1;
      end
      FINAL: begin
        for (int i = 0; i < 5; i++) h_d[i] = h_q[i] + wk_q[i];
        dv_d    = 1'b1;
        t_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      dv_q    <= 1'b0;
      h_q     <= '0;
      wk_q    <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      dv_q    <= dv_d;
      h_q     <= h_d;
      wk_q    <= wk_d;
    end
  end

  assign bus.t_out        = t_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.digest_valid = dv_q;
  assign bus.digest       = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4]};

endmodule

// File: doc/sha1_round_core.md
# sha1_round_core

SHA-1 compression engine sitting directly downstream of the SHA-1 message-schedule block. It drives the round index `t` to the schedule, consumes one schedule word `W_t` per cycle for 80 rounds, and updates the five-word working state A..E. It then adds the result into the chaining value H0..H4 and presents the 160-bit digest with a one-cycle valid pulse. Multi-block messages are processed by chaining successive blocks without reloading the IV.

## Interface
- `N`, 32, word width; only 32 is supported.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin compressing one 512-bit block; sampled only in IDLE.
- `first_blk`  in  1  sampled with `start`. 1: H <- IV before the block. 0: chain from the current H.
- `w_in`  in  N  schedule word; must equal W_k in every cycle where `t_out`=k and `busy`=1.
- `t_out`  out  8  round index to the schedule block.
- `busy`  out  1  high from the cycle after an accepted `start` through FINAL.
- `digest_valid`  out  1  one-cycle pulse; `digest` is valid in that cycle and holds until the next accepted `start`.
- `digest`  out  160  {H0,H1,H2,H3,H4}, H0 in bits [159:128].

## Operation
- States: IDLE, ROUND, FINAL.
- IDLE:
  - `t_out`=0, `busy`=0.
  - On `start`=1: if `first_blk`, H <- IV = 67452301 EFCDAB89 98BADCFE 10325476 C3D2E1F0.
  - Then load {A,B,C,D,E} <- the H that results from the step above.
  - Go to ROUND with t=0.
- ROUND, each cycle with t=k (0..79):
  - T = rotl5(A) + f_k(B,C,D) + E + K_k + w_in, all additions mod 2^32.
  - E<=D, D<=C, C<=rotl30(B), B<=A, A<=T.
  - If k=79, go to FINAL; otherwise t<=k+1.
- Round functions and constants:
  - k 0..19: f=(B&C)|(~B&D), K=5A827999.
  - k 20..39: f=B^C^D, K=6ED9EBA1.
  - k 40..59: f=(B&C)|(B&D)|(C&D), K=8F1BBCDC.
  - k 60..79: f=B^C^D, K=CA62C1D6.
- FINAL:
  - Hi <= Hi + working word i (mod 2^32) for i=0..4.
  - Assert `digest_valid` in the next cycle.
  - Return to IDLE; `t_out` returns to 0.
- `start` while `busy`=1 is ignored; no queuing and no effect on state.
- `first_blk` is ignored unless `start` is accepted.
- Reset values:
  - Entering IDLE: `t_out`=0, `busy`=0, `digest_valid`=0.
  - `digest`=0; H and A..E are all 0.
- Reset asserted mid-operation aborts the block immediately. After reset, H is 0, so the next block must use `first_blk`=1.

## Timing
- Accepted `start` at cycle c0, measured at rising edges:
  - cycles c0+1 .. c0+80: ROUND with `t_out` = 0..79, `busy`=1.
  - cycle c0+81: FINAL, `busy`=1.
  - cycle c0+82: IDLE with `digest_valid`=1 and `busy`=0.
- Block-to-block throughput: 82 cycles. `start` may be asserted in the same cycle as `digest_valid`.
- `w_in` has a combinational path only into the T adder, which is registered into A. There is no combinational path from `w_in` to any output.
- `t_out` is registered and monotonic within a block. There is no wrap-around; the counter stops at 79.

## Test plan
- Single-block "abc" (padded block 61626380 00…00 00000018), `first_blk`=1 -> `digest`=a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d, `digest_valid` at c0+82.
- Empty message (block 80000000 00…00), `first_blk`=1 -> da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmnomnopnopq":
  - block 1 with `first_blk`=1, block 2 with `first_blk`=0, back-to-back, second `start` in the `digest_valid` cycle.
  - Expected: after block 2, 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
- Pulse `start` at t=10 and t=79 of a block in progress -> ignored; "abc" digest unchanged; exactly one `digest_valid`.
- Assert `rst_n`=0 at round t=40, release, then run "abc" with `first_blk`=1:
  - during reset: `busy`=0, `digest`=0, `t_out`=0.
  - after release: correct "abc" digest.
- Hold `start` high continuously for 3 blocks with `first_blk`=1, "abc" stimulus:
  - three `digest_valid` pulses spaced 82 cycles apart.
  - each pulse shows the "abc" digest.
